// File: rtl/iir8_fir_requant.sv
// iir8_fir_requant: requantizes 8 parallel signed fixed-point lanes from the FIR section
// to 12-bit signed integers. Two-stage pipeline with valid strobe, per-lane saturation
// flags, a sticky saturation flag and a saturating event counter.
// Optional build macro IIR8_REQUANT_ROUND_EN: round-half-up instead of floor truncation.
module iir8_fir_requant #(
  parameter int unsigned NINBITS  = 24,
  parameter int unsigned NFRAC    = 10,
  parameter int unsigned NOUTBITS = 12,
  parameter int unsigned NCNTBITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NINBITS-1:0]  din,
  input  logic                  din_valid,
  output logic [8*NOUTBITS-1:0] dout,
  output logic                  dout_valid,
  output logic [7:0]            sat_lane,
  output logic                  sat_sticky,
  output logic [NCNTBITS-1:0]   sat_count,
  input  logic                  sat_clear
);

  // Width of the shifted quotient: sign-extended input minus dropped fraction bits.
  localparam int unsigned QW = NINBITS - NFRAC + 1;

  localparam logic signed [QW-1:0] QMAX =
      {{(QW - NOUTBITS + 1){1'b0}}, {(NOUTBITS - 1){1'b1}}};
  localparam logic signed [QW-1:0] QMIN = ~QMAX;

  localparam logic [NOUTBITS-1:0] OMAX = {1'b0, {(NOUTBITS - 1){1'b1}}};
  localparam logic [NOUTBITS-1:0] OMIN = {1'b1, {(NOUTBITS - 1){1'b0}}};

`ifdef IIR8_REQUANT_ROUND_EN
  localparam logic signed [NINBITS:0] RND =
      {{(NINBITS + 1 - NFRAC){1'b0}}, 1'b1, {(NFRAC - 1){1'b0}}};
`endif

  logic [8*NINBITS-1:0]  r_din;
  logic                  r_din_valid;
  logic [8*NOUTBITS-1:0] w_dout;
  logic [7:0]            w_sat_lane;
  logic                  w_event;
  logic [NCNTBITS-1:0]   r_sat_count;
  logic                  r_sat_sticky;
  logic [8*NOUTBITS-1:0] r_dout;
  logic                  r_dout_valid;
  logic [7:0]            r_sat_lane;

  // Stage 1: capture input bus and strobe every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_din       <= '0;
      r_din_valid <= 1'b0;
    end else begin
      r_din       <= din;
      r_din_valid <= din_valid;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic signed [NINBITS:0] w_x;
    logic signed [NINBITS:0] w_sum;
    logic signed [QW-1:0]    w_q;
    logic                    w_hi;
    logic                    w_lo;
    logic                    w_unused_frac;

    assign w_x = {r_din[NINBITS*k+NINBITS-1], r_din[NINBITS*k +: NINBITS]};
`ifdef IIR8_REQUANT_ROUND_EN
    // Extra guard bit means +half can never wrap.
    assign w_sum = w_x + RND;
`else
    assign w_sum = w_x;
`endif
    // Dropping the low bits of a two's-complement value is an arithmetic floor shift.
    assign w_q           = w_sum[NINBITS:NFRAC];
    assign w_unused_frac = ^w_sum[NFRAC-1:0];
    assign w_hi          = (w_q > QMAX);
    assign w_lo          = (w_q < QMIN);
    assign w_sat_lane[k] = w_hi | w_lo;
    assign w_dout[NOUTBITS*k +: NOUTBITS] = w_hi ? OMAX :
                                            w_lo ? OMIN : w_q[NOUTBITS-1:0];
  end

  // Stage 2: register requantized lanes; data follows stage 1 even when not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sat_lane   <= '0;
    end else begin
      r_dout       <= w_dout;
      r_dout_valid <= r_din_valid;
      r_sat_lane   <= w_sat_lane;
    end
  end

  // Event is taken from the presented outputs, so it lands one cycle after the beat.
  assign w_event = r_dout_valid & (|r_sat_lane);

  // Sticky flag and saturating counter; a clear colliding with an event keeps the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_count  <= '0;
      r_sat_sticky <= 1'b0;
    end else if (sat_clear) begin
      r_sat_count  <= w_event ? NCNTBITS'(1) : '0;
      r_sat_sticky <= w_event;
    end else if (w_event) begin
      r_sat_sticky <= 1'b1;
      if (r_sat_count != {NCNTBITS{1'b1}}) begin
        r_sat_count <= r_sat_count + NCNTBITS'(1);
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign sat_lane   = r_sat_lane;
  assign sat_sticky = r_sat_sticky;
  assign sat_count  = r_sat_count;

endmodule

// File: tb/tb_iir8_fir_requant.sv
// Directed self-checking bench for iir8_fir_requant: table-driven lane vectors plus
// hand-written sequences for counter, clear collision, counter saturation and reset.
module tb_iir8_fir_requant;

  logic         clk;
  logic         rst;
  logic [191:0] din;
  logic         din_valid;
  logic         sat_clear;
  logic [95:0]  dout;
  logic         dout_valid;
  logic [7:0]   sat_lane;
  logic         sat_sticky;
  logic [15:0]  sat_count;
  logic [95:0]  dout4;
  logic         dout_valid4;
  logic [7:0]   sat_lane4;
  logic         sat_sticky4;
  logic [3:0]   sat_count4;

  int n_checks = 0;
  int n_fail   = 0;
  bit round_en;

  iir8_fir_requant u_dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .sat_lane  (sat_lane),
    .sat_sticky(sat_sticky),
    .sat_count (sat_count),
    .sat_clear (sat_clear)
  );

  iir8_fir_requant #(.NCNTBITS(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout4),
    .dout_valid(dout_valid4),
    .sat_lane  (sat_lane4),
    .sat_sticky(sat_sticky4),
    .sat_count (sat_count4),
    .sat_clear (sat_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [191:0] din;
    logic [95:0]  exp_t;
    logic [95:0]  exp_r;
    logic [7:0]   sat_t;
    logic [7:0]   sat_r;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [191:0] pk_in(input logic [23:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [95:0] pk_out(input logic [11:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One beat on the bus for a single cycle.
  task automatic beat(input logic [191:0] d, input logic v);
    din       = d;
    din_valid = v;
    tick();
    din_valid = 1'b0;
  endtask

  logic [191:0] sat_beat;
  logic [191:0] clean_beat;
  byte          pat[10];

  initial begin
`ifdef IIR8_REQUANT_ROUND_EN
    round_en = 1'b1;
`else
    round_en = 1'b0;
`endif
    sat_beat   = pk_in(24'h7FFFFF, 0, 0, 0, 0, 0, 0, 0);
    clean_beat = pk_in(24'h000400, 24'h000800, 0, 0, 0, 0, 0, 0);

    vecs[0] = '{"unity", {8{24'h000400}}, {8{12'h001}}, {8{12'h001}}, 8'h00, 8'h00};
    vecs[1] = '{"round_trunc",
                pk_in(24'h000600, 24'hFFFA00, 24'h0003FF, 0, 0, 0, 0, 0),
                pk_out(12'h001, 12'hFFE, 12'h000, 0, 0, 0, 0, 0),
                pk_out(12'h002, 12'hFFF, 12'h001, 0, 0, 0, 0, 0),
                8'h00, 8'h00};
    vecs[2] = '{"sat_bounds",
                pk_in(24'h1FFC00, 24'h200000, 24'hE00000, 24'hDFFC00,
                      24'h7FFFFF, 24'h800000, 0, 0),
                pk_out(12'h7FF, 12'h7FF, 12'h800, 12'h800, 12'h7FF, 12'h800, 0, 0),
                pk_out(12'h7FF, 12'h7FF, 12'h800, 12'h800, 12'h7FF, 12'h800, 0, 0),
                8'b0011_1010, 8'b0011_1010};
    vecs[3] = '{"halves",
                pk_in(24'h1FFE00, 24'hFFFFFF, 24'h000200, 24'hFFFE00, 0, 0, 0, 0),
                pk_out(12'h7FF, 12'hFFF, 12'h000, 12'hFFF, 0, 0, 0, 0),
                pk_out(12'h7FF, 12'h000, 12'h001, 12'h000, 0, 0, 0, 0),
                8'h00, 8'h01};

    // Reset: all outputs zero while rst is held.
    rst       = 1'b1;
    din       = {8{24'h7FFFFF}};
    din_valid = 1'b1;
    sat_clear = 1'b0;
    tick();
    tick();
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_sat_lane", sat_lane, 0);
    chk("rst_sticky", sat_sticky, 0);
    chk("rst_count", sat_count, 0);
    din_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Table: check valid is low one edge in, high exactly at the second edge.
    for (int i = 0; i < 4; i++) begin
      din       = vecs[i].din;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      chk({vecs[i].name, "_early_valid"}, dout_valid, 0);
      tick();
      chk({vecs[i].name, "_valid"}, dout_valid, 1);
      chk({vecs[i].name, "_dout"}, dout, round_en ? vecs[i].exp_r : vecs[i].exp_t);
      chk({vecs[i].name, "_sat"}, sat_lane, round_en ? vecs[i].sat_r : vecs[i].sat_t);
    end
    tick();
    chk("valid_one_cycle", dout_valid, 0);
    chk("table_count", sat_count, round_en ? 2 : 1);
    chk("table_sticky", sat_sticky, 1);

    // Clear on an idle cycle.
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    chk("idle_clear_count", sat_count, 0);
    chk("idle_clear_sticky", sat_sticky, 0);

    // Counter: 5 saturating valid, 3 clean valid, 2 saturating invalid, back to back.
    pat = '{0, 1, 0, 2, 1, 0, 0, 2, 1, 0};
    for (int i = 0; i < 10; i++) begin
      din       = (pat[i] == 1) ? clean_beat : sat_beat;
      din_valid = (pat[i] != 2);
      tick();
    end
    din_valid = 1'b0;
    tick();
    chk("b2b_last_valid", dout_valid, 1);
    chk("b2b_last_dout", dout, pk_out(12'h7FF, 0, 0, 0, 0, 0, 0, 0));
    tick();
    tick();
    chk("cnt_count", sat_count, 5);
    chk("cnt_sticky", sat_sticky, 1);
    chk("cnt4_count", sat_count4, 5);

    // Clear colliding with an event: event survives.
    beat(sat_beat, 1'b1);
    tick();
    chk("coll_valid", dout_valid, 1);
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    chk("coll_count", sat_count, 1);
    chk("coll_sticky", sat_sticky, 1);
    tick();
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    chk("idle_clear2_count", sat_count, 0);
    chk("idle_clear2_sticky", sat_sticky, 0);

    // Counter saturation: 20 events; 4-bit counter pins at 15, 16-bit reaches 20.
    for (int i = 0; i < 20; i++) begin
      din       = sat_beat;
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("cnt4_sat", sat_count4, 15);
    chk("cnt16_20", sat_count, 20);
    chk("cnt4_sticky", sat_sticky4, 1);

    // Mid-stream reset: beats in flight are discarded.
    din       = sat_beat;
    din_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    din_valid = 1'b0;
    chk("mrst_valid0", dout_valid, 0);
    chk("mrst_count", sat_count, 0);
    chk("mrst_sticky", sat_sticky, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_emerge", dout_valid, 0);
    end
    chk("mrst_count_after", sat_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
